mbscore_irq_ctrl: RTL and testbench

Parametrised multi-channel interrupt controller for the MBScore CPU. It latches up to NUM_IRQ interrupt sources, per channel in level or edge mode, and applies a software mask plus the global disable int_en_n. It picks the highest-priority pending source, stalls the pipeline, and issues a vectored jump. It then holds the in-service flag until the core signals end-of-interrupt. It sits between the SoC interrupt lines and the core's fetch/PC-select logic.

---
 rtl/mbscore_irq_ctrl.sv | 154 +++++++++++++++
 tb/tb_mbscore_irq_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mbscore_irq_ctrl.sv
// mbscore_irq_ctrl
// Multi-channel vectored interrupt controller for the MBScore core.
// Latches interrupt sources (per-channel level or rising-edge mode), applies
// a software mask and the global disable, picks the lowest-numbered active
// channel, stalls the pipeline, issues a vectored jump and then holds the
// in-service flag until the core signals end-of-interrupt.
//
// Ports:
//   clk        system clock, all state changes on the rising edge
//   rst_n      synchronous active-low reset
//   irq_in     raw interrupt lines, synchronous to clk
//   int_en_n   global interrupt disable (1 = disabled)
//   mask_we    mask write strobe
//   mask_wdata new mask value, 1 = channel enabled
//   ack        core has taken the jump and saved its PC
//   eoi        core has executed return-from-interrupt
//   stop       pipeline stall request
//   set_intr   in-service flag
//   int_jump   vector valid, force PC to int_addr
//   int_addr   handler address
//   int_id     index of the channel being serviced
//   pending    raw pending vector before masking
module mbscore_irq_ctrl #(
  parameter int                    NUM_IRQ         = 8,
  parameter int                    ADDR_WIDTH      = 32,
  parameter logic [ADDR_WIDTH-1:0] VEC_BASE        = 32'h0000_0100,
  parameter int                    VEC_STRIDE_LOG2 = 4,
  parameter logic [NUM_IRQ-1:0]    EDGE_MODE       = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_IRQ-1:0]    irq_in,
  input  logic                  int_en_n,
  input  logic                  mask_we,
  input  logic [NUM_IRQ-1:0]    mask_wdata,
  input  logic                  ack,
  input  logic                  eoi,
  output logic                  stop,
  output logic                  set_intr,
  output logic                  int_jump,
  output logic [ADDR_WIDTH-1:0] int_addr,
  output logic [4:0]            int_id,
  output logic [NUM_IRQ-1:0]    pending
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STALL   = 2'd1,
    JUMP    = 2'd2,
    SERVICE = 2'd3
  } state_t;

  state_t              state;
  logic [NUM_IRQ-1:0]  irq_q;
  logic [NUM_IRQ-1:0]  edge_pend;
  logic [NUM_IRQ-1:0]  mask;
  logic [NUM_IRQ-1:0]  active;
  logic [NUM_IRQ-1:0]  clr_vec;
  logic [4:0]          sel;
  logic                req;
  logic                ack_take;
  logic [ADDR_WIDTH-1:0] vec_addr;

  // Level channels are never stored, so the visible pending vector mixes the
  // edge latch with the live irq_in lines.
  assign pending  = (edge_pend & EDGE_MODE) | (irq_in & ~EDGE_MODE);
  assign active   = pending & mask;
  assign req      = (|active) & ~int_en_n;
  assign ack_take = (state == JUMP) && ack;
  assign vec_addr = VEC_BASE + (ADDR_WIDTH'(int_id) << VEC_STRIDE_LOG2);

  // Priority pick: scanning downward lets the lowest active index win.
  always_comb begin
    sel = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (active[i]) sel = 5'(i);
    end
  end

  // Only the channel being acknowledged has its edge latch cleared.
  always_comb begin
    clr_vec = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      clr_vec[i] = ack_take && (int_id == 5'(i));
    end
  end

  // Edge detection and latching; a fresh edge in the clear cycle is ORed in
  // after the clear so the new request is not lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_q     <= '0;
      edge_pend <= '0;
    end else begin
      irq_q     <= irq_in;
      edge_pend <= ((edge_pend & ~clr_vec) | (irq_in & ~irq_q)) & EDGE_MODE;
    end
  end

  // Software mask, all channels enabled out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mask <= '1;
    end else if (mask_we) begin
      mask <= mask_wdata;
    end
  end

  // Service sequencer. Outputs are registered alongside the state so each
  // one is a clean flop; int_id is frozen at selection so a later mask
  // change or a dropped level line cannot alter the vector.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      int_id   <= '0;
      stop     <= 1'b0;
      set_intr <= 1'b0;
      int_jump <= 1'b0;
      int_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            state  <= STALL;
            int_id <= sel;
            stop   <= 1'b1;
          end
        end
        STALL: begin
          state    <= JUMP;
          stop     <= 1'b1;
          int_jump <= 1'b1;
          set_intr <= 1'b1;
          int_addr <= vec_addr;
        end
        JUMP: begin
          if (ack) begin
            state    <= SERVICE;
            stop     <= 1'b0;
            int_jump <= 1'b0;
            int_addr <= '0;
          end
        end
        SERVICE: begin
          if (eoi) begin
            state    <= IDLE;
            set_intr <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mbscore_irq_ctrl.sv
// tb_mbscore_irq_ctrl
// Directed bench for mbscore_irq_ctrl with channels 1, 3 and 5 in edge mode
// and the rest level. A behavioural model tracks each service as a record
// (busy / age / acked) and is compared against the DUT on every falling
// edge; directed steps add literal expectations taken from hand timing.
module tb_mbscore_irq_ctrl;

  localparam logic [7:0] EDGE = 8'h2A;

  logic        clk;
  logic        rst_n;
  logic [7:0]  irq_in;
  logic        int_en_n;
  logic        mask_we;
  logic [7:0]  mask_wdata;
  logic        ack;
  logic        eoi;
  logic        stop;
  logic        set_intr;
  logic        int_jump;
  logic [31:0] int_addr;
  logic [4:0]  int_id;
  logic [7:0]  pending;

  int checks = 0;
  int errors = 0;

  mbscore_irq_ctrl #(
    .NUM_IRQ(8),
    .ADDR_WIDTH(32),
    .VEC_BASE(32'h0000_0100),
    .VEC_STRIDE_LOG2(4),
    .EDGE_MODE(EDGE)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .irq_in(irq_in),
    .int_en_n(int_en_n),
    .mask_we(mask_we),
    .mask_wdata(mask_wdata),
    .ack(ack),
    .eoi(eoi),
    .stop(stop),
    .set_intr(set_intr),
    .int_jump(int_jump),
    .int_addr(int_addr),
    .int_id(int_id),
    .pending(pending)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the stimulus ever wedges.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] irq, input logic en_n,
                               input logic mwe, input logic [7:0] mwd,
                               input logic a, input logic e);
    irq_in     = irq;
    int_en_n   = en_n;
    mask_we    = mwe;
    mask_wdata = mwd;
    ack        = a;
    eoi        = e;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Wait (bounded) for int_jump; an expired budget is a failed comparison.
  task automatic waitJump(input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (int_jump === 1'b1) seen = 1;
    end
    checkOutput("jump_wait", 32'(seen), 32'd1);
  endtask

  task automatic serviceDone();
    applyStimulus(8'h00, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0);
    tick();
    applyStimulus(8'h00, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1);
    tick();
    applyStimulus(8'h00, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0);
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_pend_edge;
  logic [7:0] m_prev;
  logic [7:0] m_mask;
  bit         m_busy;
  bit         m_acked;
  int         m_age;
  int         m_id;
  bit         model_valid = 0;

  always @(posedge clk) begin
    logic [7:0] vis;
    logic [7:0] clr;
    bit         req;
    int         low;
    vis = (EDGE & m_pend_edge) | (~EDGE & irq_in);
    if (!rst_n) begin
      m_pend_edge = 8'h00;
      m_prev      = 8'h00;
      m_mask      = 8'hFF;
      m_busy      = 0;
      m_acked     = 0;
      m_age       = 0;
      m_id        = 0;
    end else begin
      req = ((vis & m_mask) != 8'h00) && !int_en_n;
      low = 0;
      for (int i = 7; i >= 0; i--) if (vis[i] && m_mask[i]) low = i;
      clr = 8'h00;
      if (m_busy) begin
        if (!m_acked) begin
          if (m_age >= 1 && ack) begin
            m_acked  = 1;
            clr[m_id] = 1'b1;
          end
          m_age++;
        end else if (eoi) begin
          m_busy = 0;
        end
      end else if (req) begin
        m_busy  = 1;
        m_acked = 0;
        m_age   = 0;
        m_id    = low;
      end
      m_pend_edge = ((m_pend_edge & ~clr) | (irq_in & ~m_prev)) & EDGE;
      m_prev      = irq_in;
      if (mask_we) m_mask = mask_wdata;
    end
    model_valid = 1;
  end

  // Compare every output against the model away from the active edge.
  always @(negedge clk) begin
    if (model_valid) begin
      logic        e_jump;
      logic        e_stop;
      logic        e_set;
      logic [31:0] e_addr;
      e_stop = m_busy && !m_acked;
      e_jump = m_busy && !m_acked && (m_age >= 1);
      e_set  = m_busy && (m_acked || m_age >= 1);
      e_addr = e_jump ? (32'h100 + 32'(m_id) * 32'd16) : 32'h0;
      checkOutput("m_stop", 32'(stop), 32'(e_stop));
      checkOutput("m_int_jump", 32'(int_jump), 32'(e_jump));
      checkOutput("m_set_intr", 32'(set_intr), 32'(e_set));
      checkOutput("m_int_addr", int_addr, e_addr);
      checkOutput("m_int_id", 32'(int_id), 32'(m_id));
      checkOutput("m_pending", 32'(pending),
                  32'((EDGE & m_pend_edge) | (~EDGE & irq_in)));
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0;
    applyStimulus(8'hFF, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    tick();
    $display("[TB] reset");
    checkOutput("rst_stop", 32'(stop), 32'd0);
    checkOutput("rst_set_intr", 32'(set_intr), 32'd0);
    checkOutput("rst_int_jump", 32'(int_jump), 32'd0);
    checkOutput("rst_int_addr", int_addr, 32'd0);
    checkOutput("rst_int_id", 32'(int_id), 32'd0);
    checkOutput("rst_pend_edge", 32'(pending & EDGE), 32'd0);
    applyStimulus(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single edge request on channel 3
    $display("[TB] single edge request");
    applyStimulus(8'h08, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    checkOutput("e0_pend3", 32'(pending[3]), 32'd1);
    checkOutput("e0_stop", 32'(stop), 32'd0);
    applyStimulus(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    checkOutput("e1_stop", 32'(stop), 32'd1);
    checkOutput("e1_jump", 32'(int_jump), 32'd0);
    tick();
    checkOutput("e2_jump", 32'(int_jump), 32'd1);
    checkOutput("e2_addr", int_addr, 32'h0000_0130);
    checkOutput("e2_id", 32'(int_id), 32'd3);
    applyStimulus(8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    checkOutput("ack_pend3", 32'(pending[3]), 32'd0);
    checkOutput("ack_set_intr", 32'(set_intr), 32'd1);
    checkOutput("ack_jump", 32'(int_jump), 32'd0);
    applyStimulus(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    checkOutput("eoi_set_intr", 32'(set_intr), 32'd0);
    applyStimulus(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();

    // Priority between channels 5 and 1
    $display("[TB] priority");
    applyStimulus(8'h22, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    applyStimulus(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    waitJump(6);
    checkOutput("pri_id1", 32'(int_id), 32'd1);
    checkOutput("pri_addr1", int_addr, 32'h0000_0110);
    serviceDone();
    waitJump(6);
    checkOutput("pri_id5", 32'(int_id), 32'd5);
    checkOutput("pri_addr5", int_addr, 32'h0000_0150);
    serviceDone();
    tick();

    // Masking channel 3
    $display("[TB] masking");
    applyStimulus(8'h00, 1'b0, 1'b1, 8'hF7, 1'b0, 1'b0);
    tick();
    applyStimulus(8'h08, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    applyStimulus(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    checkOutput("mask_stop", 32'(stop), 32'd0);
    checkOutput("mask_pend3", 32'(pending[3]), 32'd1);
    applyStimulus(8'h00, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
    tick();
    applyStimulus(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    waitJump(6);
    checkOutput("unmask_id", 32'(int_id), 32'd3);
    serviceDone();
    tick();

    // Global disable with a level request on channel 6
    $display("[TB] global disable");
    applyStimulus(8'h40, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    checkOutput("dis_stop", 32'(stop), 32'd0);
    applyStimulus(8'h40, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    checkOutput("lvl_stall", 32'(stop), 32'd1);
    // Drop the line and re-disable mid-flight; the vector must still issue.
    applyStimulus(8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    waitJump(4);
    checkOutput("lvl_id", 32'(int_id), 32'd6);
    checkOutput("lvl_addr", int_addr, 32'h0000_0160);
    serviceDone();
    tick();

    // Withheld ack, stray eoi, and a re-edge in the ack cycle
    $display("[TB] ack stall");
    applyStimulus(8'h08, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    applyStimulus(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    waitJump(6);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, (i == 5));
      tick();
      checkOutput("hold_jump", 32'(int_jump), 32'd1);
      checkOutput("hold_addr", int_addr, 32'h0000_0130);
    end
    applyStimulus(8'h08, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    checkOutput("reedge_pend3", 32'(pending[3]), 32'd1);
    checkOutput("reedge_set", 32'(set_intr), 32'd1);
    applyStimulus(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    applyStimulus(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    waitJump(6);
    checkOutput("reedge_id", 32'(int_id), 32'd3);
    serviceDone();
    tick();

    // Reset during JUMP
    $display("[TB] abort");
    applyStimulus(8'h20, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    applyStimulus(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    waitJump(6);
    rst_n = 1'b0;
    tick();
    checkOutput("abort_stop", 32'(stop), 32'd0);
    checkOutput("abort_jump", 32'(int_jump), 32'd0);
    checkOutput("abort_set", 32'(set_intr), 32'd0);
    checkOutput("abort_addr", int_addr, 32'd0);
    checkOutput("abort_id", 32'(int_id), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    checkOutput("post_abort_stop", 32'(stop), 32'd0);

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
